// File: rtl/interrupt_injector.sv
// Queues interrupt instruction words from the input controller and injects them into the fetch
// stream one at a time. Each injection holds the PC for one cycle, and no new injection starts
// until the running handler signals completion.
module interrupt_injector #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DROP_W = 8
) (
  input  logic              proc_clk,
  input  logic              reset_n,
  input  logic [31:0]       intr_instruction_in,
  input  logic              fetch_stall,
  input  logic              branch_pending,
  input  logic              handler_done,
  output logic              inject_valid,
  output logic [31:0]       inject_instruction,
  output logic              pc_hold,
  output logic              in_handler,
  output logic [PTR_W:0]    pending_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, IN_HANDLER} state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                inject_valid_q, inject_valid_d;
  logic [31:0]         inject_instr_q, inject_instr_d;
  logic                in_handler_q, in_handler_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;
  logic                push, pop, push_ok;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // Pop decisions use the pre-edge count, so a word pushed this cycle cannot be popped until the next.
  always_comb begin
    push    = |intr_instruction_in;
    pop     = (state_q == IDLE) && (count_q != '0) && !fetch_stall && !branch_pending;
    push_ok = push && ((count_q < (PTR_W+1)'(DEPTH)) || pop);

    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    inject_valid_d = inject_valid_q;
    inject_instr_d = inject_instr_q;
    in_handler_d   = in_handler_q;
    overflow_d     = overflow_q;
    drop_count_d   = drop_count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = intr_instruction_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else if (push) begin
      overflow_d   = 1'b1;
      drop_count_d = sat_inc(drop_count_q);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d        = ISSUE;
          inject_valid_d = 1'b1;
          inject_instr_d = mem_q[rd_ptr_q];
          in_handler_d   = 1'b1;
          rd_ptr_d       = rd_ptr_q + PTR_W'(1);
        end
      end
      ISSUE: begin
        state_d        = IN_HANDLER;
        inject_valid_d = 1'b0;
        inject_instr_d = '0;
      end
      IN_HANDLER: begin
        if (handler_done) begin
          state_d      = IDLE;
          in_handler_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge proc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      inject_valid_q <= 1'b0;
      inject_instr_q <= '0;
      in_handler_q   <= 1'b0;
      overflow_q     <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      inject_valid_q <= inject_valid_d;
      inject_instr_q <= inject_instr_d;
      in_handler_q   <= in_handler_d;
      overflow_q     <= overflow_d;
      drop_count_q   <= drop_count_d;
    end
  end

  // Storage is not reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge proc_clk) begin
    mem_q <= mem_d;
  end

  assign inject_valid       = inject_valid_q;
  assign pc_hold            = inject_valid_q;
  assign inject_instruction = inject_instr_q;
  assign in_handler         = in_handler_q;
  assign pending_count      = count_q;
  assign overflow           = overflow_q;
  assign drop_count         = drop_count_q;

endmodule

// File: tb/tb_interrupt_injector.sv
// Scoreboard bench for interrupt_injector: directed pushes enqueue the expected injection order,
// and a monitor pops and compares on every inject_valid pulse.
module tb_interrupt_injector;

  logic        proc_clk = 1'b0;
  logic        reset_n;
  logic [31:0] intr_instruction_in;
  logic        fetch_stall, branch_pending, handler_done;
  logic        inject_valid, pc_hold, in_handler, overflow;
  logic [31:0] inject_instruction;
  logic [2:0]  pending_count;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_inj = -100;
  logic prev_valid = 1'b0;
  logic [31:0] expq [$];

  interrupt_injector #(.DEPTH(4), .PTR_W(2), .DROP_W(8)) dut (
    .proc_clk(proc_clk), .reset_n(reset_n), .intr_instruction_in(intr_instruction_in),
    .fetch_stall(fetch_stall), .branch_pending(branch_pending), .handler_done(handler_done),
    .inject_valid(inject_valid), .inject_instruction(inject_instruction), .pc_hold(pc_hold),
    .in_handler(in_handler), .pending_count(pending_count), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 proc_clk = ~proc_clk;
  always @(posedge proc_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares each injected word against the scoreboard and checks pulse shape.
  always @(negedge proc_clk) begin
    if (reset_n) begin
      chk("pc_hold_eq_valid", pc_hold, inject_valid);
      if (inject_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_inject", inject_instruction, 32'h0);
          checks++; errors++;
          $display("FAIL unexpected_inject got %h expected none", inject_instruction);
        end else begin
          chk("inject_word", inject_instruction, expq.pop_front());
        end
        chk("pulse_width_1", prev_valid, 1'b0);
        chk("spacing_ge3", (cyc - last_inj >= 3), 1'b1);
        last_inj = cyc;
      end else begin
        chk("instr_zero_idle", inject_instruction, 32'h0);
      end
      prev_valid = inject_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge proc_clk); #1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_inject);
    intr_instruction_in = w;
    if (expect_inject) expq.push_back(w);
    tick();
    intr_instruction_in = '0;
  endtask

  task automatic wait_handler();
    int n = 0;
    while (!(in_handler && !inject_valid) && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_handler got timeout expected in_handler");
    end
  endtask

  task automatic pulse_done();
    handler_done = 1'b1; tick(); handler_done = 1'b0;
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      wait_handler();
      pulse_done();
    end
  endtask

  initial begin
    reset_n = 1'b0; intr_instruction_in = '0; fetch_stall = 1'b0;
    branch_pending = 1'b0; handler_done = 1'b0;
    #12;
    chk("rst_valid", inject_valid, 0);     chk("rst_pc_hold", pc_hold, 0);
    chk("rst_in_handler", in_handler, 0);  chk("rst_pending", pending_count, 0);
    chk("rst_overflow", overflow, 0);      chk("rst_drop", drop_count, 0);
    chk("rst_instr", inject_instruction, 0);
    @(negedge proc_clk); reset_n = 1'b1;
    tick();

    // Basic path
    push_word(32'hA000_0001, 1);
    chk("basic_pend1", pending_count, 1); chk("basic_novalid", inject_valid, 0);
    tick();
    chk("basic_pend0", pending_count, 0); chk("basic_valid", inject_valid, 1);
    chk("basic_instr", inject_instruction, 32'hA000_0001);
    tick();
    chk("basic_valid_off", inject_valid, 0); chk("basic_inh", in_handler, 1);
    tick(); tick();
    chk("basic_inh_hold", in_handler, 1);
    pulse_done();
    chk("basic_inh_clr", in_handler, 0);

    // Ordering and blocking
    branch_pending = 1'b1;
    push_word(32'h11, 1); push_word(32'h22, 1); push_word(32'h33, 1);
    tick();
    chk("order_pend3", pending_count, 3); chk("order_blocked", inject_valid, 0);
    branch_pending = 1'b0;
    serve(3);
    tick();
    chk("order_pend0", pending_count, 0);

    // Overflow
    fetch_stall = 1'b1;
    for (int i = 1; i <= 6; i++) push_word(32'h100 + i, i <= 4);
    chk("ovf_pend4", pending_count, 4); chk("ovf_flag", overflow, 1);
    chk("ovf_drop2", drop_count, 2);
    fetch_stall = 1'b0;
    serve(4);
    tick(); tick(); tick();
    chk("ovf_drained", pending_count, 0);

    // Full plus simultaneous push and pop
    fetch_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(32'h200 + i, 1);
    chk("full_pend4", pending_count, 4);
    fetch_stall = 1'b0;
    push_word(32'h55, 1);
    chk("full_pp_pend4", pending_count, 4); chk("full_pp_drop", drop_count, 2);
    chk("full_pp_valid", inject_valid, 1);
    serve(5);
    tick();

    // Stray handler_done in IDLE, push during IN_HANDLER
    pulse_done();
    chk("stray_inh", in_handler, 0); chk("stray_valid", inject_valid, 0);
    chk("stray_pend", pending_count, 0);
    push_word(32'h301, 1);
    wait_handler();
    push_word(32'h302, 1);
    chk("nest_pend1", pending_count, 1);
    tick(); tick();
    chk("nest_noinject", inject_valid, 0); chk("nest_pend_hold", pending_count, 1);
    pulse_done();
    serve(1);
    tick();

    // Reset mid-handler
    fetch_stall = 1'b1;
    push_word(32'h401, 1); push_word(32'h402, 0); push_word(32'h403, 0);
    fetch_stall = 1'b0;
    wait_handler();
    chk("pre_rst_pend2", pending_count, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_inh", in_handler, 0);   chk("mid_rst_pend", pending_count, 0);
    chk("mid_rst_ovf", overflow, 0);     chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_valid", inject_valid, 0); chk("mid_rst_pc", pc_hold, 0);
    chk("mid_rst_instr", inject_instruction, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_pend", pending_count, 0); chk("post_rst_inh", in_handler, 0);
    chk("scoreboard_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/interrupt_injector.md
Name: interrupt_injector

Overview:
- CPU-side receiver for the one-cycle interrupt instruction words produced by the input/frame-timing controller.
- Buffers incoming interrupt instructions in a small FIFO.
- Injects each one into the processor fetch stream at a safe point, holding the PC for that cycle.
- Blocks further injection until the handler signals completion; no nested interrupts.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).
- DROP_W, 8, width of the saturating dropped-interrupt counter.

Ports:
- proc_clk  in  1  processor clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- intr_instruction_in  in  32  interrupt word from the input controller; any nonzero value is a push request for that cycle; 0 = none.
- fetch_stall  in  1  fetch stage stalled this cycle; no injection allowed.
- branch_pending  in  1  unresolved branch/jump in the pipeline; no injection allowed.
- handler_done  in  1  one-cycle pulse when the handler's return instruction commits.
- inject_valid  out  1  injected instruction presented to fetch this cycle.
- inject_instruction  out  32  instruction to substitute at fetch; 0 when inject_valid=0.
- pc_hold  out  1  freeze PC increment; equals inject_valid.
- in_handler  out  1  high from the injection cycle until handler_done is accepted.
- pending_count  out  PTR_W+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was dropped since reset.
- drop_count  out  DROP_W  number of dropped pushes; saturates at all-ones.

Behaviour:
- Reset (reset_n=0, async):
  - FIFO pointers and count = 0; state = IDLE.
  - inject_valid, pc_hold, in_handler, overflow = 0.
  - inject_instruction = 0; drop_count = 0.
- All other state updates occur on posedge proc_clk. Every output is registered.
- Push:
  - Condition: intr_instruction_in != 0 at a rising edge.
  - If count < DEPTH, or a pop occurs in the same cycle: word written at the write pointer; pointer wraps DEPTH-1 → 0.
  - Otherwise the word is dropped, overflow ← 1, and drop_count increments unless saturated.
- Pop occurs only on the IDLE→ISSUE transition. The head word is loaded into inject_instruction; the read pointer wraps.
- Count arithmetic:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - Full plus simultaneous push and pop: push accepted, no drop.
- Order: strict FIFO; earliest arrival is injected first.
- FSM states: IDLE, ISSUE, IN_HANDLER.
  - IDLE → ISSUE: count != 0 and fetch_stall=0 and branch_pending=0, sampled at the edge. The pop happens on this edge.
  - ISSUE lasts exactly one cycle. inject_valid = pc_hold = 1, in_handler = 1.
  - ISSUE → IN_HANDLER unconditionally. inject_valid ← 0, inject_instruction ← 0.
  - IN_HANDLER → IDLE on handler_done=1. in_handler ← 0.
  - handler_done in IDLE or ISSUE is ignored.
- Latency:
  - A push at edge N into an empty FIFO, with IDLE and no blocking, gives inject_valid high in the cycle after edge N+1.
  - The FIFO does not bypass: a word must be written before it can be popped.
- Back-to-back injections:
  - After handler_done at edge M, the next queued word can issue at edge M+1 earliest.
  - Minimum spacing between inject_valid pulses is therefore 3 cycles.
- Blocking: fetch_stall or branch_pending only delay IDLE→ISSUE. Once in ISSUE, the pulse completes regardless of later stalls; fetch must honour pc_hold.
- Pushes continue to be accepted in every state, including ISSUE and IN_HANDLER.
- Reset asserted mid-operation: all queued words are discarded, and any in-progress ISSUE or IN_HANDLER is abandoned to IDLE immediately.

Test Plan:
- Basic path: push 0xA000_0001 for one cycle with stall and branch low → pending_count goes 1 then 0; inject_valid and pc_hold high for exactly 1 cycle with inject_instruction=0xA000_0001; in_handler=1 until a handler_done pulse, then 0.
- Ordering and blocking: push 0x11, 0x22, 0x33 on consecutive cycles while branch_pending=1 → pending_count=3, no inject; release branch_pending and pulse handler_done after each issue → injects occur in order 0x11, 0x22, 0x33, at least 3 cycles apart.
- Overflow: with fetch_stall=1, push 6 distinct words → pending_count=4, overflow=1, drop_count=2; after draining, only the first 4 words are injected.
- Full plus simultaneous push/pop: fill to 4, release the stall and push 0x55 on the IDLE→ISSUE edge → pending_count stays 4, drop_count unchanged, 0x55 is injected last.
- Stray and nested events: handler_done pulsed while in IDLE → no state change; push during IN_HANDLER → queued, not injected until after handler_done.
- Reset mid-handler: queue 2 words and assert reset_n=0 asynchronously during IN_HANDLER → all outputs 0 immediately (before the next edge); after release, no injection occurs without new pushes.
